// File: rtl/dll_nch.sv
// dll_nch: multi-channel behavioural DLL for the AIB receive clock path.
// Each channel searches a delay code driven by its phase detector and
// raises lock after LOCK_FLIPS direction reversals. Lock handshakes are
// routed to the master or slave side according to ms_nsl.
// Optional feature macro: DLL_TRACK_EN -- when defined, a locked channel
// keeps adjusting its code from pd_up; otherwise the code freezes on lock.
`timescale 1ps/1ps
module dll_nch #(
  parameter int NCH         = 2,
  parameter int CODE_W      = 4,
  parameter int CODE_INIT   = 8,
  parameter int SETTLE_CYC  = 3,
  parameter int LOCK_FLIPS  = 2,
  parameter int BASE_DLY_PS = 100,
  parameter int TAP_PS      = 10
) (
  input  logic                  clkp,
  input  logic                  rstb,
  input  logic                  clkn,
  input  logic                  atpg_mode,
  input  logic                  ms_nsl,
  input  logic [NCH-1:0]        ms_rx_dll_lock_req,
  input  logic [NCH-1:0]        sl_rx_dll_lock_req,
  input  logic [NCH-1:0]        pd_up,
  output logic [NCH-1:0]        ms_rx_dll_lock,
  output logic [NCH-1:0]        sl_rx_dll_lock,
  output logic [NCH*CODE_W-1:0] dly_code,
  output logic [NCH-1:0]        rx_clk_tree_in
);

  localparam int CNT_W  = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int FLIP_W = 4;
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(SETTLE_CYC);
  localparam logic [FLIP_W-1:0] FLIP_LAST   = FLIP_W'(LOCK_FLIPS - 1);
  localparam logic [CODE_W-1:0] CODE_INIT_C = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0] CODE_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // clkn exists only for pin compatibility with the single-channel model
  logic unused_clkn;
  assign unused_clkn = clkn;

  // Saturating +/-1 step of a delay code
  function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] c,
                                                  input logic up);
    if (up)
      return (c == CODE_MAX) ? c : c + 1'b1;
    else
      return (c == '0) ? c : c - 1'b1;
  endfunction

  // Reset synchroniser: asynchronous assertion, release after two clkp edges
  logic [1:0] rst_sync_reg;
  logic       rstb_sync;

  always_ff @(posedge clkp or negedge rstb) begin
    if (!rstb) rst_sync_reg <= 2'b00;
    else       rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  // Test mode drives the raw reset straight into the core
  assign rstb_sync = atpg_mode ? rstb : rst_sync_reg[1];

  // Two-flop synchronisers for the asynchronous lock requests
  logic [NCH-1:0] ms_req_meta_reg, ms_req_sync_reg;
  logic [NCH-1:0] sl_req_meta_reg, sl_req_sync_reg;
  logic [NCH-1:0] req;
  logic [NCH-1:0] lock;

  always_ff @(posedge clkp or negedge rstb_sync) begin
    if (!rstb_sync) begin
      ms_req_meta_reg <= '0;
      ms_req_sync_reg <= '0;
      sl_req_meta_reg <= '0;
      sl_req_sync_reg <= '0;
    end else begin
      ms_req_meta_reg <= ms_rx_dll_lock_req;
      ms_req_sync_reg <= ms_req_meta_reg;
      sl_req_meta_reg <= sl_rx_dll_lock_req;
      sl_req_sync_reg <= sl_req_meta_reg;
    end
  end

  // A side switch only re-selects the request; lock follows the selected side
  assign req            = ms_nsl ? ms_req_sync_reg : sl_req_sync_reg;
  assign ms_rx_dll_lock = ms_nsl ? lock : '0;
  assign sl_rx_dll_lock = ms_nsl ? '0 : lock;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t            state_reg, state_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [FLIP_W-1:0] flip_reg, flip_next;
    logic              prev_dir_reg, prev_dir_next;
    logic              prev_vld_reg, prev_vld_next;
    logic              lock_reg, lock_next;
    logic              sample_hit;

    // Channel state, code and search bookkeeping registers
    always_ff @(posedge clkp or negedge rstb_sync) begin
      if (!rstb_sync) begin
        state_reg    <= ST_IDLE;
        code_reg     <= CODE_INIT_C;
        cnt_reg      <= '0;
        flip_reg     <= '0;
        prev_dir_reg <= 1'b0;
        prev_vld_reg <= 1'b0;
        lock_reg     <= 1'b0;
      end else begin
        state_reg    <= state_next;
        code_reg     <= code_next;
        cnt_reg      <= cnt_next;
        flip_reg     <= flip_next;
        prev_dir_reg <= prev_dir_next;
        prev_vld_reg <= prev_vld_next;
        lock_reg     <= lock_next;
      end
    end

    // Next-state: request gating, periodic pd sampling, flip counting, lock
    always_comb begin
      state_next    = state_reg;
      code_next     = code_reg;
      cnt_next      = cnt_reg;
      flip_next     = flip_reg;
      prev_dir_next = prev_dir_reg;
      prev_vld_next = prev_vld_reg;
      lock_next     = lock_reg;
      sample_hit    = (cnt_reg == CNT_LAST);

      if (!req[gi] || state_reg == ST_IDLE) begin
        state_next    = req[gi] ? ST_SEARCH : ST_IDLE;
        code_next     = CODE_INIT_C;
        cnt_next      = '0;
        flip_next     = '0;
        prev_dir_next = 1'b0;
        prev_vld_next = 1'b0;
        lock_next     = 1'b0;
      end else begin
        case (state_reg)
          ST_SEARCH: begin
            if (sample_hit) begin
              cnt_next      = '0;
              code_next     = step_code(code_reg, pd_up[gi]);
              prev_dir_next = pd_up[gi];
              prev_vld_next = 1'b1;
              if (prev_vld_reg && (prev_dir_reg != pd_up[gi])) begin
                flip_next = flip_reg + 1'b1;
                if (flip_reg == FLIP_LAST) begin
                  state_next = ST_LOCKED;
                  lock_next  = 1'b1;
                end
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          ST_LOCKED: begin
            lock_next = 1'b1;
`ifdef DLL_TRACK_EN
            if (sample_hit) begin
              cnt_next  = '0;
              code_next = step_code(code_reg, pd_up[gi]);
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
`else
            cnt_next = '0;
`endif
          end
          default: begin
            state_next = ST_IDLE;
            lock_next  = 1'b0;
          end
        endcase
      end
    end

    assign lock[gi]                       = lock_reg;
    assign dly_code[gi*CODE_W +: CODE_W]  = code_reg;

`ifndef SYNTHESIS
    logic rx_clk_reg;
    // Transport-delayed copy of clkp; the delay tracks the live code
    always @(clkp) rx_clk_reg <= #(BASE_DLY_PS + int'(code_reg) * TAP_PS) clkp;
    assign rx_clk_tree_in[gi] = rx_clk_reg;
`else
    assign rx_clk_tree_in[gi] = clkp;
`endif
  end

endmodule

// File: tb/tb_dll_nch.sv
// tb_dll_nch: table-driven check of dll_nch (2 channels, default params),
// plus hand sequences for delay, saturation and asynchronous reset.
`timescale 1ps/1ps
module tb_dll_nch;

  localparam int NCH = 2;
  localparam int CW  = 4;
`ifdef DLL_TRACK_EN
  localparam logic [3:0] TRK_CODE = 4'd11;
`else
  localparam logic [3:0] TRK_CODE = 4'd9;
`endif

  logic           clkp = 1'b0;
  logic           clkn;
  logic           rstb;
  logic           atpg_mode;
  logic           ms_nsl;
  logic [NCH-1:0] ms_req, sl_req, pd_up;
  logic [NCH-1:0] ms_lock, sl_lock, rx_clk;
  logic [NCH*CW-1:0] dly_code;

  int tests = 0;
  int fails = 0;

  always #500 clkp = ~clkp;
  assign clkn = ~clkp;

  dll_nch #(.NCH(NCH), .CODE_W(CW), .CODE_INIT(8), .SETTLE_CYC(3),
            .LOCK_FLIPS(2), .BASE_DLY_PS(100), .TAP_PS(10)) dut (
    .clkp(clkp), .rstb(rstb), .clkn(clkn), .atpg_mode(atpg_mode),
    .ms_nsl(ms_nsl), .ms_rx_dll_lock_req(ms_req), .sl_rx_dll_lock_req(sl_req),
    .pd_up(pd_up), .ms_rx_dll_lock(ms_lock), .sl_rx_dll_lock(sl_lock),
    .dly_code(dly_code), .rx_clk_tree_in(rx_clk)
  );

  typedef struct {
    logic       ms_nsl;
    logic [1:0] ms_req;
    logic [1:0] sl_req;
    logic [1:0] pd;
    int         adv;
    logic [1:0] e_ms;
    logic [1:0] e_sl;
    logic [3:0] e_c0;
    logic [3:0] e_c1;
  } vec_t;

  vec_t vecs[15];

  task automatic adv_edges(input int n);
    repeat (n) @(posedge clkp);
    #100;
  endtask

  task automatic check_out(input string name, input logic [1:0] e_ms,
                           input logic [1:0] e_sl, input logic [3:0] e_c0,
                           input logic [3:0] e_c1);
    tests++;
    if (ms_lock !== e_ms || sl_lock !== e_sl ||
        dly_code[3:0] !== e_c0 || dly_code[7:4] !== e_c1) begin
      fails++;
      $display("FAIL %s: got ms_lock=%b sl_lock=%b code0=%0d code1=%0d, want ms_lock=%b sl_lock=%b code0=%0d code1=%0d",
               name, ms_lock, sl_lock, dly_code[3:0], dly_code[7:4], e_ms, e_sl, e_c0, e_c1);
    end else begin
      $display("[TB] ok %s: ms_lock=%b sl_lock=%b code0=%0d code1=%0d",
               name, ms_lock, sl_lock, dly_code[3:0], dly_code[7:4]);
    end
  endtask

  // rx_clk[ch] must still be low 10 ps before and high 10 ps after exp_ps
  task automatic check_dly(input string name, input int ch, input int exp_ps);
    logic before_v, after_v;
    @(posedge clkp);
    #(exp_ps - 10);
    before_v = rx_clk[ch];
    #20;
    after_v = rx_clk[ch];
    tests++;
    if (before_v !== 1'b0 || after_v !== 1'b1) begin
      fails++;
      $display("FAIL %s: ch%0d rx_clk at %0d/%0d ps = %b/%b, want 0/1",
               name, ch, exp_ps - 10, exp_ps + 10, before_v, after_v);
    end else begin
      $display("[TB] ok %s: ch%0d rise at %0d ps", name, ch, exp_ps);
    end
  endtask

  initial begin
    // ms_nsl, ms_req, sl_req, pd, adv, e_ms, e_sl, e_c0, e_c1
    vecs[0]  = '{1'b1, 2'b01, 2'b00, 2'b01, 6, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[1]  = '{1'b1, 2'b01, 2'b00, 2'b01, 1, 2'b00, 2'b00, 4'd9, 4'd8};
    vecs[2]  = '{1'b1, 2'b01, 2'b00, 2'b10, 3, 2'b00, 2'b00, 4'd9, 4'd8};
    vecs[3]  = '{1'b1, 2'b01, 2'b00, 2'b10, 1, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[4]  = '{1'b1, 2'b01, 2'b00, 2'b11, 3, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[5]  = '{1'b1, 2'b01, 2'b00, 2'b11, 1, 2'b01, 2'b00, 4'd9, 4'd8};
    vecs[6]  = '{1'b1, 2'b01, 2'b00, 2'b11, 8, 2'b01, 2'b00, TRK_CODE, 4'd8};
    vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'b11, 2, 2'b01, 2'b00, TRK_CODE, 4'd8};
    vecs[8]  = '{1'b1, 2'b00, 2'b00, 2'b11, 1, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[9]  = '{1'b0, 2'b01, 2'b10, 2'b10, 7, 2'b00, 2'b00, 4'd8, 4'd9};
    vecs[10] = '{1'b0, 2'b01, 2'b10, 2'b00, 4, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[11] = '{1'b0, 2'b01, 2'b10, 2'b10, 4, 2'b00, 2'b10, 4'd8, 4'd9};
    vecs[12] = '{1'b1, 2'b01, 2'b10, 2'b11, 1, 2'b00, 2'b00, 4'd8, 4'd8};
    vecs[13] = '{1'b1, 2'b01, 2'b10, 2'b11, 4, 2'b00, 2'b00, 4'd9, 4'd8};
    vecs[14] = '{1'b1, 2'b00, 2'b00, 2'b00, 3, 2'b00, 2'b00, 4'd8, 4'd8};

    rstb = 1'b0; atpg_mode = 1'b0; ms_nsl = 1'b1;
    ms_req = '0; sl_req = '0; pd_up = '0;

    // Reset state and base clock-tree delay
    adv_edges(4);
    check_out("reset", 2'b00, 2'b00, 4'd8, 4'd8);
    check_dly("reset_dly", 0, 180);
    check_dly("reset_dly", 1, 180);

    adv_edges(1);
    rstb = 1'b1;
    adv_edges(3);
    check_out("post_reset", 2'b00, 2'b00, 4'd8, 4'd8);

    // Table: lock, tracking, drop, slave routing, side switch
    for (int i = 0; i < 15; i++) begin
      ms_nsl = vecs[i].ms_nsl;
      ms_req = vecs[i].ms_req;
      sl_req = vecs[i].sl_req;
      pd_up  = vecs[i].pd;
      adv_edges(vecs[i].adv);
      check_out($sformatf("row%0d", i), vecs[i].e_ms, vecs[i].e_sl,
                vecs[i].e_c0, vecs[i].e_c1);
    end

    // Saturation: pd_up held high, code tops out at 15 without locking
    adv_edges(3);
    ms_nsl = 1'b1; ms_req = 2'b01; sl_req = 2'b00; pd_up = 2'b01;
    adv_edges(30);
    check_out("sat_30", 2'b00, 2'b00, 4'd14, 4'd8);
    adv_edges(1);
    check_out("sat_31", 2'b00, 2'b00, 4'd15, 4'd8);
    check_dly("sat_dly", 0, 250);
    adv_edges(13);
    check_out("sat_45", 2'b00, 2'b00, 4'd15, 4'd8);
    ms_req = 2'b00;
    adv_edges(2);
    check_out("sat_drop2", 2'b00, 2'b00, 4'd15, 4'd8);
    adv_edges(1);
    check_out("sat_drop3", 2'b00, 2'b00, 4'd8, 4'd8);

    // Asynchronous reset assertion between clock edges
    ms_req = 2'b01;
    adv_edges(10);
    check_out("pre_async", 2'b00, 2'b00, 4'd9, 4'd8);
    #200;
    rstb = 1'b0;
    #10;
    check_out("async_rst", 2'b00, 2'b00, 4'd8, 4'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dll_nch.md
# dll_nch

Parametrised multi-channel behavioural DLL for the AIB receive clock path. It replaces the single-channel fixed-delay model with NCH independent channels. Each channel runs a phase-detector-driven delay-code search, reports lock only after the code has settled, and drives its own delayed receive clock tree. Per-channel lock-request and lock handshakes are routed to the master or slave side according to `ms_nsl`.

## Interface
Parameters:
- `NCH`, 2: number of independent DLL channels (1..16).
- `CODE_W`, 4: delay-code width per channel.
- `CODE_INIT`, 8: code loaded in reset and IDLE; must be < 2^CODE_W.
- `SETTLE_CYC`, 3: idle cycles between phase-detector samples; sample period P = SETTLE_CYC+1.
- `LOCK_FLIPS`, 2: direction reversals required to declare lock (1..15).
- `BASE_DLY_PS`, 100: fixed clock-tree delay, simulation only.
- `TAP_PS`, 10: delay per code step, simulation only.

Ports:
- `clkp`  in  1  reference clock; all flops on its rising edge.
- `rstb`  in  1  asynchronous active-low reset.
- `clkn`  in  1  complementary clock; unused, kept for pin compatibility.
- `atpg_mode`  in  1  bypasses the internal reset synchroniser.
- `ms_nsl`  in  1  1 = master side, 0 = slave side.
- `ms_rx_dll_lock_req`  in  NCH  per-channel master lock request, asynchronous.
- `sl_rx_dll_lock_req`  in  NCH  per-channel slave lock request, asynchronous.
- `pd_up`  in  NCH  phase-detector output per channel: 1 = increase delay, 0 = decrease delay; synchronous to `clkp`.
- `ms_rx_dll_lock`  out  NCH  per-channel master lock.
- `sl_rx_dll_lock`  out  NCH  per-channel slave lock.
- `dly_code`  out  NCH*CODE_W  current code; channel c occupies bits [c*CODE_W +: CODE_W].
- `rx_clk_tree_in`  out  NCH  delayed clock per channel.

## Operation
- `rstb` is asserted asynchronously and deasserted through a 2-flop synchroniser on `clkp`. When `atpg_mode` = 1 the synchroniser is bypassed and `rstb` is used directly.
- Both request vectors pass through 2-flop bit synchronisers. Selected request `req[c]` = `ms_nsl` ? `ms_req_sync[c]` : `sl_req_sync[c]`.
- Lock routing:
  - `ms_nsl` = 1: `ms_rx_dll_lock[c]` = `lock[c]` and `sl_rx_dll_lock` = 0.
  - `ms_nsl` = 0: routing is mirrored.
- Per-channel FSM, states IDLE, SEARCH, LOCKED:
  - **IDLE:** code = `CODE_INIT`, lock = 0, sample counter = 0, flip count = 0, previous direction marked invalid. On `req` = 1, go to SEARCH.
  - **SEARCH:** the sample counter counts 0..SETTLE_CYC. When the counter equals SETTLE_CYC, sample `pd_up`:
    - code += 1 when `pd_up` = 1, code -= 1 when `pd_up` = 0.
    - The code saturates at 2^CODE_W−1 and at 0; a saturated sample still counts as a sample.
    - If the previous direction is valid and differs from the current one, flip count += 1.
    - Store the current direction as previous.
    - When flip count reaches `LOCK_FLIPS` on a sample edge, go to LOCKED on that same edge.
  - **LOCKED:** lock = 1. Code tracking is described under Configuration.
  - **Any state:** `req` = 0 returns the channel to IDLE on the next edge. Lock is 0 from that edge and the code is reloaded to `CODE_INIT`.
- A change of `ms_nsl` mid-operation only changes the selected request. If the newly selected request is 0, the channel returns to IDLE.
- Channels are fully independent. Simultaneous requests on all channels are legal.
- `rx_clk_tree_in[c]` = `clkp` delayed by `BASE_DLY_PS` + `dly_code[c]`*`TAP_PS` ps. This is a transport delay, simulation only, not synthesised.

## Timing
- Reset values:
  - All lock outputs = 0.
  - `dly_code` = `CODE_INIT` on every channel.
  - FSM = IDLE.
  - `rx_clk_tree_in` follows `clkp` with code `CODE_INIT` delay.
- Request latency: a request stable before edge 1 is visible as `req` at edge 2. The FSM enters SEARCH at edge 3.
- The first sample occurs P edges after SEARCH entry; subsequent samples occur every P edges.
- Lock and `dly_code` are registered outputs. Both update on the sample edge itself.
- Request drop: lock falls 3 edges after the raw request falls (2 for the synchroniser + 1 for the FSM).

## Configuration
- `DLL_TRACK_EN`:
  - **Defined:** in LOCKED, the code keeps adjusting ±1 (saturating) every P cycles from `pd_up`, and lock stays 1.
  - **Undefined:** in LOCKED, the code is frozen and the sample counter is idle.

## Test plan
- **Reset:** `rstb` = 0 with `CODE_INIT` = 8 -> all locks 0, every `dly_code` field = 8, `rx_clk_tree_in` delay = 180 ps.
- **Lock sequence:** `ms_nsl` = 1, `ms_rx_dll_lock_req[0]` rises before edge 1, `pd_up[0]` = 1, 0, 1 at edges 7, 11, 15 -> code 9, 8, 9; `ms_rx_dll_lock[0]` = 1 after edge 15; `sl_rx_dll_lock` stays 0.
- **Saturation:** `pd_up` held at 1 for 10 samples from code 8 -> code stops at 15, no flips, no lock.
- **Request drop:** drop the request while LOCKED -> lock = 0 three edges later, code = 8.
- **Channel independence:** channel 1 held IDLE while channel 0 locks -> channel 1 code stays 8 and its lock stays 0.
- **Tracking:** with `DLL_TRACK_EN`, LOCKED and `pd_up` = 1 for 2 samples -> code +2, lock stays 1. Without the macro, the code is unchanged.
